// File: rtl/cipu_pkg.sv
// Shared types and constants for the CIPU feeder: FSM states, stream
// delimiter bytes and preload select codes.
package cipu_pkg;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_FEED,
      ST_DRAIN,
      ST_DONE,
      ST_TMO
   } state_e;

   localparam logic [7:0] CH_END = 8'h24;   // '$' terminates a stream
   localparam logic [7:0] CH_SEP = 8'h3B;   // ';' closes a thing group

   localparam logic [1:0] SEL_PEOPLE = 2'd0;
   localparam logic [1:0] SEL_THING  = 2'd1;
   localparam logic [1:0] SEL_TABLE  = 2'd2;

endpackage

// File: rtl/cipu_feeder_if.sv
// Byte-stream link between the feeder (master) and the CIPU (slave).
interface cipu_feeder_if;
   logic       ready_fifo;
   logic [7:0] people_thing_in;
   logic       ready_lifo;
   logic [7:0] thing_in;
   logic [3:0] thing_num;
   logic       valid_fifo;
   logic       valid_lifo;
   logic       valid_fifo2;
   logic [7:0] people_thing_out;
   logic [7:0] thing_out;
   logic       done_fifo;
   logic       done_lifo;
   logic       done_fifo2;
   logic       done_thing;

   modport master (
      output ready_fifo, people_thing_in, ready_lifo, thing_in, thing_num,
      input  valid_fifo, valid_lifo, valid_fifo2, people_thing_out, thing_out,
      input  done_fifo, done_lifo, done_fifo2, done_thing
   );

   modport slave (
      input  ready_fifo, people_thing_in, ready_lifo, thing_in, thing_num,
      output valid_fifo, valid_lifo, valid_fifo2, people_thing_out, thing_out,
      output done_fifo, done_lifo, done_fifo2, done_thing
   );
endinterface

// File: rtl/cipu_feed_buf.sv
// DEPTH x 8 byte RAM, one write port and one registered read port.
// Contents are not reset.
module cipu_feed_buf #(
   parameter int DEPTH = 32
) (
   input  logic                     clk_i,
   input  logic                     we_i,
   input  logic [$clog2(DEPTH)-1:0] waddr_i,
   input  logic [7:0]               wdata_i,
   input  logic [$clog2(DEPTH)-1:0] raddr_i,
   output logic [7:0]               rdata_o
);

   logic [7:0] mem_q [DEPTH];

   // write port plus one-cycle-latency read
   always_ff @(posedge clk_i) begin
      if (we_i) mem_q[waddr_i] <= wdata_i;
      rdata_o <= mem_q[raddr_i];
   end

endmodule

// File: rtl/cipu_feeder.sv
// CIPU feeder: preloaded people/thing byte streams are played into the CIPU,
// its output strobes are counted, and completion / timeout are reported.
// Optional feature macro: CIPU_FEED_CAPTURE_EN (capture CIPU output bytes).
module cipu_feeder
   import cipu_pkg::*;
#(
   parameter int DEPTH   = 32,
   parameter int GROUPS  = 8,
   parameter int TIMEOUT = 1023
) (
   input  logic                     clk_i,
   input  logic                     rst_ni,
   input  logic                     wr_en_i,
   input  logic [1:0]               wr_sel_i,
   input  logic [$clog2(DEPTH)-1:0] wr_addr_i,
   input  logic [7:0]               wr_data_i,
   input  logic                     start_i,
   cipu_feeder_if.master            cipu,
   output logic                     busy_o,
   output logic                     run_done_o,
   output logic                     timeout_o,
   output logic [5:0]               cnt_fifo_o,
   output logic [5:0]               cnt_lifo_o,
   output logic [5:0]               cnt_fifo2_o,
   input  logic [$clog2(DEPTH)-1:0] rd_addr_i,
   input  logic [1:0]               rd_sel_i,
   output logic [7:0]               rd_data_o
);

   localparam int AW = $clog2(DEPTH);
   localparam int GW = $clog2(GROUPS);
   localparam int TW = $clog2(TIMEOUT + 1);
   localparam logic [AW-1:0] LAST_A   = AW'(DEPTH - 1);
   localparam logic [AW-1:0] G_NUM    = AW'(GROUPS);
   localparam logic [GW-1:0] G_LAST   = GW'(GROUPS - 1);
   localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT - 1);

   state_e state_q, state_d;
   logic   go, run, wr_ok, feed_fin, sep_sent;

   // side 0 = people, side 1 = thing
   logic [1:0]         act_q, act_d, fin_q, fin_d, last_s;
   logic [1:0][AW-1:0] addr_q, addr_d, raddr;
   logic [1:0][7:0]    rdata, byte_s;

   logic [GW-1:0]          g_q, g_d;
   logic [3:0]             tn_q, tn_d;
   logic [GROUPS-1:0][3:0] tbl_q;
   logic [2:0]             vld;
   logic [2:0][5:0]        cnt_q, cnt_d;
   logic [TW-1:0]          tmr_q, tmr_d;
   logic                   run_done_q, run_done_d, timeout_q, timeout_d;
   logic                   unused_ok;

   assign go    = start_i && (state_q == ST_IDLE || state_q == ST_DONE || state_q == ST_TMO);
   assign run   = (state_q == ST_FEED) || (state_q == ST_DRAIN);
   assign wr_ok = wr_en_i && (state_q == ST_IDLE || state_q == ST_DONE);
   assign vld   = {cipu.valid_fifo2, cipu.valid_lifo, cipu.valid_fifo};

   // stream buffers; read address runs one ahead so data lines up with ready
   for (genvar gi = 0; gi < 2; gi++) begin : g_src
      cipu_feed_buf #(.DEPTH(DEPTH)) u_buf (
         .clk_i   (clk_i),
         .we_i    (wr_ok && wr_sel_i == ((gi == 0) ? SEL_PEOPLE : SEL_THING)),
         .waddr_i (wr_addr_i),
         .wdata_i (wr_data_i),
         .raddr_i (raddr[gi]),
         .rdata_o (rdata[gi])
      );
   end

   // per-side sequencer: walk addresses until '$' (forced at the last slot)
   always_comb begin
      for (int i = 0; i < 2; i++) begin
         byte_s[i] = (addr_q[i] == LAST_A) ? CH_END : rdata[i];
         last_s[i] = act_q[i] && (byte_s[i] == CH_END);
         raddr[i]  = act_q[i] ? addr_q[i] + 1'b1 : '0;
         act_d[i]  = act_q[i];
         addr_d[i] = addr_q[i];
         fin_d[i]  = fin_q[i];
         if (go) begin
            act_d[i]  = 1'b1;
            addr_d[i] = '0;
            fin_d[i]  = 1'b0;
         end else if (act_q[i]) begin
            addr_d[i] = addr_q[i] + 1'b1;
            if (last_s[i]) begin
               act_d[i] = 1'b0;
               fin_d[i] = 1'b1;
            end
         end
      end
   end

   assign feed_fin = &(fin_q | last_s);
   assign sep_sent = act_q[1] && (byte_s[1] == CH_SEP);

   // group index and registered pop count; held outside FEED
   always_comb begin
      g_d  = g_q;
      tn_d = tn_q;
      if (go) begin
         g_d  = '0;
         tn_d = tbl_q[0];
      end else if (state_q == ST_FEED) begin
         if (sep_sent && g_q != G_LAST) g_d = g_q + 1'b1;
         tn_d = tbl_q[g_d];
      end
   end

   // pop-count table preload (no reset: survives a mid-run reset)
   always_ff @(posedge clk_i) begin
      if (wr_ok && wr_sel_i == SEL_TABLE && wr_addr_i < G_NUM)
         tbl_q[wr_addr_i[GW-1:0]] <= wr_data_i[3:0];
   end

   // saturating strobe counters, cleared at start
   always_comb begin
      for (int i = 0; i < 3; i++) begin
         cnt_d[i] = cnt_q[i];
         if (go) cnt_d[i] = '0;
         else if (run && vld[i] && cnt_q[i] != 6'd63) cnt_d[i] = cnt_q[i] + 1'b1;
      end
   end

   // FSM next state, drain timer and status flags
   always_comb begin
      state_d   = state_q;
      tmr_d     = (state_q == ST_DRAIN) ? tmr_q + 1'b1 : '0;
      timeout_d = timeout_q;
      case (state_q)
         ST_IDLE, ST_DONE, ST_TMO: if (start_i) state_d = ST_FEED;
         ST_FEED:                  if (feed_fin) state_d = ST_DRAIN;
         ST_DRAIN: begin
            if (cipu.done_fifo && cipu.done_fifo2) state_d = ST_DONE;
            else if (tmr_q == TMO_LAST)            state_d = ST_TMO;
         end
         default:                  state_d = ST_IDLE;
      endcase
      run_done_d = (state_d != state_q) && (state_d == ST_DONE || state_d == ST_TMO);
      if (go) timeout_d = 1'b0;
      else if (state_d == ST_TMO && state_q != ST_TMO) timeout_d = 1'b1;
   end

   // state registers
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q    <= ST_IDLE;
         act_q      <= '0;
         fin_q      <= '0;
         addr_q     <= '0;
         g_q        <= '0;
         tn_q       <= '0;
         cnt_q      <= '0;
         tmr_q      <= '0;
         run_done_q <= 1'b0;
         timeout_q  <= 1'b0;
      end else begin
         state_q    <= state_d;
         act_q      <= act_d;
         fin_q      <= fin_d;
         addr_q     <= addr_d;
         g_q        <= g_d;
         tn_q       <= tn_d;
         cnt_q      <= cnt_d;
         tmr_q      <= tmr_d;
         run_done_q <= run_done_d;
         timeout_q  <= timeout_d;
      end
   end

   assign cipu.ready_fifo      = act_q[0];
   assign cipu.people_thing_in = act_q[0] ? byte_s[0] : 8'h00;
   assign cipu.ready_lifo      = act_q[1];
   assign cipu.thing_in        = act_q[1] ? byte_s[1] : 8'h00;
   assign cipu.thing_num       = tn_q;
   assign busy_o      = run;
   assign run_done_o  = run_done_q;
   assign timeout_o   = timeout_q;
   assign cnt_fifo_o  = cnt_q[0];
   assign cnt_lifo_o  = cnt_q[1];
   assign cnt_fifo2_o = cnt_q[2];

`ifdef CIPU_FEED_CAPTURE_EN
   localparam logic [6:0] DEPTH_C = 7'(DEPTH);
   logic [2:0][7:0] cap_rd;
   logic [1:0]      rd_sel_q;

   // capture each valid byte at its pre-increment count while room remains
   for (genvar gi = 0; gi < 3; gi++) begin : g_cap
      cipu_feed_buf #(.DEPTH(DEPTH)) u_cap (
         .clk_i   (clk_i),
         .we_i    (run && vld[gi] && ({1'b0, cnt_q[gi]} < DEPTH_C)),
         .waddr_i (cnt_q[gi][AW-1:0]),
         .wdata_i ((gi == 1) ? cipu.thing_out : cipu.people_thing_out),
         .raddr_i (rd_addr_i),
         .rdata_o (cap_rd[gi])
      );
   end

   // select is delayed to line up with the RAM read latency
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) rd_sel_q <= '0;
      else         rd_sel_q <= rd_sel_i;
   end

   // capture read mux
   always_comb begin
      rd_data_o = 8'h00;
      case (rd_sel_q)
         2'd0:    rd_data_o = cap_rd[0];
         2'd1:    rd_data_o = cap_rd[1];
         2'd2:    rd_data_o = cap_rd[2];
         default: rd_data_o = 8'h00;
      endcase
   end

   assign unused_ok = ^{cipu.done_lifo, cipu.done_thing};
`else
   assign rd_data_o = 8'h00;
   assign unused_ok = ^{cipu.done_lifo, cipu.done_thing, rd_addr_i, rd_sel_i,
                        cipu.people_thing_out, cipu.thing_out};
`endif

endmodule

// File: tb/tb_cipu_feeder.sv
// Self-checking bench for cipu_feeder: scoreboard queues hold the expected
// people/thing bytes and pop counts; a negedge monitor pops and compares them
// whenever the feeder presents a byte. The main sequence models the CIPU.
module tb_cipu_feeder;
   import cipu_pkg::*;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       wr_en = 1'b0;
   logic [1:0] wr_sel = '0;
   logic [4:0] wr_addr = '0;
   logic [7:0] wr_data = '0;
   logic       start = 1'b0;
   logic       busy, run_done, timeout;
   logic [5:0] cnt_fifo, cnt_lifo, cnt_fifo2;
   logic [4:0] rd_addr = '0;
   logic [1:0] rd_sel = '0;
   logic [7:0] rd_data;

   always #5 clk = ~clk;

   cipu_feeder_if cif();

   cipu_feeder dut (
      .clk_i       (clk),
      .rst_ni      (rst_n),
      .wr_en_i     (wr_en),
      .wr_sel_i    (wr_sel),
      .wr_addr_i   (wr_addr),
      .wr_data_i   (wr_data),
      .start_i     (start),
      .cipu        (cif),
      .busy_o      (busy),
      .run_done_o  (run_done),
      .timeout_o   (timeout),
      .cnt_fifo_o  (cnt_fifo),
      .cnt_lifo_o  (cnt_lifo),
      .cnt_fifo2_o (cnt_fifo2),
      .rd_addr_i   (rd_addr),
      .rd_sel_i    (rd_sel),
      .rd_data_o   (rd_data)
   );

   int n_tests = 0;
   int n_fail  = 0;
   int rf_cyc  = 0;
   int rl_cyc  = 0;
   logic [7:0] pq[$];
   logic [7:0] tq[$];
   logic [3:0] nq[$];

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // scoreboard monitor
   always @(negedge clk) begin
      if (rst_n) begin
         if (cif.ready_fifo) begin
            rf_cyc++;
            if (pq.size() == 0) chk("p_extra", 1, 0);
            else                chk("p_byte", cif.people_thing_in, pq.pop_front());
         end
         if (cif.ready_lifo) begin
            rl_cyc++;
            if (tq.size() == 0) chk("t_extra", 1, 0);
            else begin
               chk("t_byte", cif.thing_in, tq.pop_front());
               chk("t_num", cif.thing_num, nq.pop_front());
            end
         end
      end
   end

   task automatic wr(input logic [1:0] s, input logic [4:0] a, input logic [7:0] d);
      wr_en = 1'b1; wr_sel = s; wr_addr = a; wr_data = d;
      @(negedge clk);
      wr_en = 1'b0;
   endtask

   task automatic load_str(input logic [1:0] s, input string str);
      for (int i = 0; i < str.len(); i++) wr(s, 5'(i), str[i]);
   endtask

   task automatic do_start();
      string ps = "AB$";
      string ts = "ab;c;$";
      logic [3:0] nums [6] = '{4'd2, 4'd2, 4'd2, 4'd1, 4'd1, 4'd5};
      for (int i = 0; i < ps.len(); i++) pq.push_back(ps[i]);
      for (int i = 0; i < ts.len(); i++) begin
         tq.push_back(ts[i]);
         nq.push_back(nums[i]);
      end
      rf_cyc = 0; rl_cyc = 0;
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
   endtask

   task automatic wait_drain();
      bit ok = 1'b0;
      for (int i = 0; i < 60 && !ok; i++) begin
         if (busy && !cif.ready_fifo && !cif.ready_lifo) ok = 1'b1;
         else @(negedge clk);
      end
      chk("reach_drain", ok, 1);
   endtask

   // CIPU model: two fifo/fifo2 strobes (bytes 61,62) then done
   task automatic finish_run();
      bit seen = 1'b0;
      wait_drain();
      chk("ready_fifo_cycles", rf_cyc, 3);
      chk("ready_lifo_cycles", rl_cyc, 6);
      cif.valid_fifo = 1'b1; cif.valid_fifo2 = 1'b1; cif.people_thing_out = 8'h61;
      @(negedge clk);
      cif.people_thing_out = 8'h62;
      @(negedge clk);
      cif.valid_fifo = 1'b0; cif.valid_fifo2 = 1'b0;
      cif.done_fifo = 1'b1; cif.done_fifo2 = 1'b1;
      for (int i = 0; i < 8 && !seen; i++) begin
         @(negedge clk);
         if (run_done) seen = 1'b1;
      end
      chk("run_done_pulse", seen, 1);
      chk("busy_done", busy, 0);
      chk("timeout_done", timeout, 0);
      chk("cnt_fifo", cnt_fifo, 2);
      chk("cnt_fifo2", cnt_fifo2, 2);
      chk("pq_left", pq.size(), 0);
      chk("tq_left", tq.size(), 0);
      cif.done_fifo = 1'b0; cif.done_fifo2 = 1'b0;
      @(negedge clk);
      chk("run_done_1cyc", run_done, 0);
   endtask

   initial begin
      cif.valid_fifo = 1'b0; cif.valid_lifo = 1'b0; cif.valid_fifo2 = 1'b0;
      cif.people_thing_out = '0; cif.thing_out = '0;
      cif.done_fifo = 1'b0; cif.done_lifo = 1'b0; cif.done_fifo2 = 1'b0; cif.done_thing = 1'b0;
      repeat (2) @(negedge clk);
      chk("rst_busy", busy, 0);
      chk("rst_ready_fifo", cif.ready_fifo, 0);
      chk("rst_ready_lifo", cif.ready_lifo, 0);
      chk("rst_thing_num", cif.thing_num, 0);
      chk("rst_run_done", run_done, 0);
      chk("rst_timeout", timeout, 0);
      chk("rst_cnt_fifo", cnt_fifo, 0);
      rst_n = 1'b1;
      @(negedge clk);

      load_str(SEL_PEOPLE, "AB$");
      load_str(SEL_THING, "ab;c;$");
      wr(SEL_TABLE, 5'd0, 8'd2);
      wr(SEL_TABLE, 5'd1, 8'd1);
      wr(SEL_TABLE, 5'd2, 8'd5);

      // run 1: normal completion
      do_start();
      chk("busy_feed", busy, 1);
      finish_run();

      // run 2: CIPU never finishes; also saturate cnt_lifo
      do_start();
      wait_drain();
      begin
         int  dc = 0;
         bit  seen = 1'b0;
         for (int i = 0; i < 1100 && !seen; i++) begin
            if (run_done) seen = 1'b1;
            else begin
               if (busy) dc++;
               cif.valid_lifo = (i < 70);
               @(negedge clk);
            end
         end
         cif.valid_lifo = 1'b0;
         chk("tmo_pulse", seen, 1);
         chk("drain_cycles", dc, 1023);
         chk("timeout_set", timeout, 1);
         chk("busy_tmo", busy, 0);
         chk("cnt_lifo_sat", cnt_lifo, 63);
      end

      // run 3: start clears timeout; a write during FEED must be dropped
      do_start();
      chk("timeout_clr", timeout, 0);
      chk("cnt_lifo_clr", cnt_lifo, 0);
      wr(SEL_PEOPLE, 5'd0, 8'h5A);
      finish_run();

      // run 4: reset mid-FEED
      do_start();
      cif.valid_fifo = 1'b1;
      @(negedge clk);
      chk("cnt_before_rst", cnt_fifo, 1);
      rst_n = 1'b0;
      #1;
      chk("midrst_ready_fifo", cif.ready_fifo, 0);
      chk("midrst_ready_lifo", cif.ready_lifo, 0);
      chk("midrst_cnt", cnt_fifo, 0);
      chk("midrst_busy", busy, 0);
      cif.valid_fifo = 1'b0;
      @(negedge clk);
      pq.delete(); tq.delete(); nq.delete();
      rst_n = 1'b1;
      @(negedge clk);

      // run 5: clean rerun, identical stream expected
      do_start();
      finish_run();

      // capture read port
      rd_sel = 2'd2; rd_addr = 5'd0;
      @(negedge clk);
`ifdef CIPU_FEED_CAPTURE_EN
      chk("cap_fifo2_0", rd_data, 8'h61);
`else
      chk("rd_tied0", rd_data, 8'h00);
`endif
      rd_addr = 5'd1;
      @(negedge clk);
`ifdef CIPU_FEED_CAPTURE_EN
      chk("cap_fifo2_1", rd_data, 8'h62);
`else
      chk("rd_tied0_b", rd_data, 8'h00);
`endif
      rd_sel = 2'd0; rd_addr = 5'd0;
      @(negedge clk);
`ifdef CIPU_FEED_CAPTURE_EN
      chk("cap_fifo_0", rd_data, 8'h61);
`else
      chk("rd_tied0_c", rd_data, 8'h00);
`endif

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: got no finish, required finish before 500000");
      $fatal(1, "watchdog expired");
   end

endmodule
